// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the interrupt controller.
package cpu_pkg;
  localparam int PC_W      = 10;
  localparam int VEC_SHIFT = 4;
  localparam int N_IRQ     = 4;
  localparam int IDX_W     = $clog2(N_IRQ);
  localparam logic [PC_W-1:0] VEC_BASE = 10'h3C0;

  typedef enum logic [1:0] {IDLE, ENTER, SERVICE, EXIT} irq_state_t;

  // Lowest set index wins; bit 0 is highest priority.
  function automatic logic [IDX_W-1:0] prio_enc(input logic [N_IRQ-1:0] req);
    prio_enc = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (req[i]) prio_enc = IDX_W'(i);
  endfunction
endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector for one irq line.
module irq_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic irq_i,
  output logic edge_o
);
  logic s1_q, s2_q, last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      last_q <= 1'b0;
    end else begin
      s1_q   <= irq_i;
      s2_q   <= s1_q;
      last_q <= s2_q;
    end
  end

  assign edge_o = s2_q & ~last_q;
endmodule

// File: rtl/irq_ctrl.sv
// Four-source interrupt controller: pending latch, fixed-priority arbitration,
// one-cycle ENTER (push + vector) and one-cycle EXIT (pop) sequencing.
module irq_ctrl
  import cpu_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic             mask_we_i,
  input  logic [N_IRQ-1:0] mask_d_i,
  input  logic             ei_i,
  input  logic             di_i,
  input  logic             iret_i,
  input  logic [PC_W-1:0]  pc_in_i,
  output logic             int_take_o,
  output logic             suppress_o,
  output logic [PC_W-1:0]  vector_o,
  output logic             ret_push_o,
  output logic [PC_W-1:0]  ret_addr_o,
  output logic             ret_pop_o,
  output logic [N_IRQ-1:0] pending_o,
  output logic [N_IRQ-1:0] in_service_o,
  output logic             gie_o
);
  irq_state_t       state_q, state_d;
  logic [N_IRQ-1:0] edge_w;
  logic [N_IRQ-1:0] pend_q, pend_d, mask_q, mask_d, insvc_q, insvc_d, clr_w;
  logic [IDX_W-1:0] win_q, win_d;
  logic             gie_q, gie_d, sgie_q, sgie_d;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_sync
    irq_sync_edge u_sync (.clk_i(clk_i), .rst_ni(rst_ni), .irq_i(irq_i[i]), .edge_o(edge_w[i]));
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    insvc_d = insvc_q;
    gie_d   = gie_q;
    sgie_d  = sgie_q;
    clr_w   = '0;
    mask_d  = mask_we_i ? mask_d_i : mask_q;
    case (state_q)
      IDLE: begin
        if (di_i)      gie_d = 1'b0;
        else if (ei_i) gie_d = 1'b1;
        if (gie_q && |(pend_q & mask_q)) begin
          state_d = ENTER;
          win_d   = prio_enc(pend_q & mask_q);
        end
      end
      ENTER: begin
        clr_w   = N_IRQ'(1) << win_q;
        insvc_d = N_IRQ'(1) << win_q;
        gie_d   = 1'b0;
        sgie_d  = 1'b1;
        state_d = SERVICE;
      end
      SERVICE: begin
        // No nesting: ei has no effect here, di only affects the restored gie.
        if (di_i)   sgie_d  = 1'b0;
        if (iret_i) state_d = EXIT;
      end
      EXIT: begin
        insvc_d = '0;
        gie_d   = sgie_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A fresh edge beats the acknowledge clear on the same bit.
    pend_d = (pend_q & ~clr_w) | edge_w;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      win_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      insvc_q <= '0;
      gie_q   <= 1'b0;
      sgie_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      insvc_q <= insvc_d;
      gie_q   <= gie_d;
      sgie_q  <= sgie_d;
    end
  end

  assign int_take_o   = (state_q == ENTER);
  assign ret_push_o   = int_take_o;
  assign ret_pop_o    = (state_q == EXIT);
  assign suppress_o   = int_take_o | ret_pop_o;
  assign vector_o     = int_take_o ? VEC_BASE + (PC_W'(win_q) << VEC_SHIFT) : '0;
  assign ret_addr_o   = int_take_o ? pc_in_i : '0;
  assign pending_o    = pend_q;
  assign in_service_o = insvc_q;
  assign gie_o        = gie_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl.
module tb_irq_ctrl;
  logic       clk, rst_n;
  logic [3:0] irq, mask_d, pending, in_service;
  logic       mask_we, ei, di, iret;
  logic [9:0] pc_in, vector, ret_addr;
  logic       int_take, suppress, ret_push, ret_pop, gie;
  int vecs = 0;
  int errs = 0;

  irq_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n), .irq_i(irq), .mask_we_i(mask_we), .mask_d_i(mask_d),
    .ei_i(ei), .di_i(di), .iret_i(iret), .pc_in_i(pc_in),
    .int_take_o(int_take), .suppress_o(suppress), .vector_o(vector),
    .ret_push_o(ret_push), .ret_addr_o(ret_addr), .ret_pop_o(ret_pop),
    .pending_o(pending), .in_service_o(in_service), .gie_o(gie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_take"}, 16'(int_take), 16'd0);
    chk({tag, "_supp"}, 16'(suppress), 16'd0);
    chk({tag, "_push"}, 16'(ret_push), 16'd0);
    chk({tag, "_pop"},  16'(ret_pop),  16'd0);
    chk({tag, "_vec"},  16'(vector),   16'd0);
    chk({tag, "_raddr"},16'(ret_addr), 16'd0);
  endtask

  task automatic do_iret();
    iret = 1'b1; tick(); iret = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq = '0; mask_we = 1'b0; mask_d = '0; ei = 1'b0; di = 1'b0;
    iret = 1'b0; pc_in = 10'h123;
    #12;
    chk_idle_outs("rst");
    chk("rst_pend", 16'(pending), 16'h0);
    chk("rst_insvc", 16'(in_service), 16'h0);
    chk("rst_gie", 16'(gie), 16'h0);
    rst_n = 1'b1;
    tick();

    mask_we = 1'b1; mask_d = 4'b1111; ei = 1'b1;
    tick();
    mask_we = 1'b0; ei = 1'b0;
    chk("ei_gie", 16'(gie), 16'h1);

    // T1: irq[2] rises before edge k; ENTER after edge k+3
    irq[2] = 1'b1;
    tick(); tick();
    chk("t1_pend0", 16'(pending), 16'h0);
    tick();
    chk("t1_pend", 16'(pending), 16'h4);
    chk("t1_take0", 16'(int_take), 16'h0);
    tick();
    chk("t1_take", 16'(int_take), 16'h1);
    chk("t1_vec", 16'(vector), 16'h3E0);
    chk("t1_raddr", 16'(ret_addr), 16'h123);
    chk("t1_push", 16'(ret_push), 16'h1);
    chk("t1_supp", 16'(suppress), 16'h1);
    tick();
    chk("t1_take1", 16'(int_take), 16'h0);
    chk("t1_insvc", 16'(in_service), 16'h4);
    chk("t1_gie", 16'(gie), 16'h0);
    chk("t1_pclr", 16'(pending), 16'h0);
    do_iret();
    chk("t1_pop", 16'(ret_pop), 16'h1);
    chk("t1_xsupp", 16'(suppress), 16'h1);
    chk("t1_xtake", 16'(int_take), 16'h0);
    tick();
    chk("t1_idle_insvc", 16'(in_service), 16'h0);
    chk("t1_idle_gie", 16'(gie), 16'h1);
    chk("t1_idle_pop", 16'(ret_pop), 16'h0);
    irq[2] = 1'b0;
    tick(); tick(); tick();

    // T2: irq[3] and irq[1] together; source 1 first
    irq[3] = 1'b1; irq[1] = 1'b1;
    tick(); tick(); tick();
    chk("t2_pend", 16'(pending), 16'hA);
    tick();
    chk("t2_vec1", 16'(vector), 16'h3D0);
    tick();
    chk("t2_insvc1", 16'(in_service), 16'h2);
    chk("t2_pend8", 16'(pending), 16'h8);
    tick(); tick();
    chk("t2_hold_take", 16'(int_take), 16'h0);
    chk("t2_hold_pend", 16'(pending), 16'h8);
    do_iret();
    chk("t2_pop", 16'(ret_pop), 16'h1);
    tick();
    chk("t2_idle_take", 16'(int_take), 16'h0);
    tick();
    chk("t2_take3", 16'(int_take), 16'h1);
    chk("t2_vec3", 16'(vector), 16'h3F0);
    tick();
    chk("t2_insvc3", 16'(in_service), 16'h8);
    chk("t2_pend0", 16'(pending), 16'h0);
    do_iret(); tick();
    irq = '0;
    tick(); tick(); tick();

    // T3: masked source stays pending until unmasked
    mask_we = 1'b1; mask_d = 4'b1011;
    tick();
    mask_we = 1'b0;
    irq[2] = 1'b1;
    tick(); tick(); tick();
    chk("t3_pend", 16'(pending), 16'h4);
    tick(); tick();
    chk("t3_nomask_take", 16'(int_take), 16'h0);
    chk("t3_still_pend", 16'(pending), 16'h4);
    mask_we = 1'b1; mask_d = 4'b1111;
    tick();
    mask_we = 1'b0;
    chk("t3_take_early", 16'(int_take), 16'h0);
    tick();
    chk("t3_take", 16'(int_take), 16'h1);
    chk("t3_vec", 16'(vector), 16'h3E0);
    tick();
    chk("t3_insvc", 16'(in_service), 16'h4);

    // T4: same source re-fires during its own service
    irq[2] = 1'b0;
    tick(); tick(); tick();
    irq[2] = 1'b1;
    tick(); tick(); tick();
    chk("t4_pend", 16'(pending), 16'h4);
    chk("t4_insvc", 16'(in_service), 16'h4);
    tick();
    chk("t4_no_nest", 16'(int_take), 16'h0);
    do_iret();
    chk("t4_exit_take", 16'(int_take), 16'h0);
    tick();
    chk("t4_idle_take", 16'(int_take), 16'h0);
    tick();
    chk("t4_retake", 16'(int_take), 16'h1);
    chk("t4_vec", 16'(vector), 16'h3E0);
    tick();
    chk("t4_svc", 16'(in_service), 16'h4);

    // T5: ei+di together in SERVICE, di wins across return
    irq[0] = 1'b1;
    tick(); tick(); tick();
    chk("t5_pend", 16'(pending), 16'h1);
    ei = 1'b1; di = 1'b1;
    tick();
    ei = 1'b0; di = 1'b0;
    chk("t5_gie_svc", 16'(gie), 16'h0);
    do_iret(); tick();
    chk("t5_gie", 16'(gie), 16'h0);
    chk("t5_insvc", 16'(in_service), 16'h0);
    tick(); tick();
    chk("t5_no_take", 16'(int_take), 16'h0);
    chk("t5_pend_held", 16'(pending), 16'h1);

    // T6: reset mid-handler
    ei = 1'b1; tick(); ei = 1'b0;
    chk("t6_gie", 16'(gie), 16'h1);
    tick();
    chk("t6_take", 16'(int_take), 16'h1);
    chk("t6_vec", 16'(vector), 16'h3C0);
    tick();
    chk("t6_insvc", 16'(in_service), 16'h1);
    irq = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_insvc", 16'(in_service), 16'h0);
    chk("t6_rst_pend", 16'(pending), 16'h0);
    chk("t6_rst_gie", 16'(gie), 16'h0);
    chk_idle_outs("t6_rst");
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    chk("t6_post_take", 16'(int_take), 16'h0);
    chk("t6_post_pend", 16'(pending), 16'h0);
    chk("t6_post_insvc", 16'(in_service), 16'h0);
    chk("t6_post_gie", 16'(gie), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
